// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment scan path: the hex glyph table
// (active-low a..g, bit 0 = a), the special blank/minus patterns, the
// decoder FSM state type and the pattern <-> nibble helpers.
package sseg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'h3F;

   // Entry k is the active-low pattern for hex digit k.
   localparam logic [15:0][6:0] GLYPH_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CAPTURE,
      ST_HOLD
   } state_t;

   typedef struct packed {
      logic       hit;
      logic [3:0] nibble;
   } glyph_hit_t;

   // Reverse lookup of a 7-bit segment pattern; hit=0 when no hex glyph matches.
   function automatic glyph_hit_t glyph_to_nibble(input logic [6:0] pattern);
      glyph_hit_t result;
      result = '0;
      for (int k = 0; k < 16; k++) begin
         if (GLYPH_TABLE[k] == pattern) begin
            result.hit    = 1'b1;
            result.nibble = 4'(k);
         end
      end
      return result;
   endfunction

   // Forward lookup used by the display driver's encoder.
   function automatic logic [6:0] nibble_to_glyph(input logic [3:0] nibble);
      return GLYPH_TABLE[nibble];
   endfunction

endpackage

// File: rtl/sseg_scan_decoder_if.sv
// Scan bus (active-low seg/an) plus the decoded readback of all four digits.
// The master side drives the scan bus; the slave side is the decoder.
interface sseg_scan_decoder_if;

   logic [7:0]  seg;
   logic [3:0]  an;
   logic [15:0] digits;
   logic [3:0]  known;
   logic [3:0]  blank;
   logic [3:0]  minus;
   logic [3:0]  dp;
   logic        frame_done;
   logic        multi_err;
   logic        stale;

   modport master (
      output seg, an,
      input  digits, known, blank, minus, dp, frame_done, multi_err, stale
   );

   modport slave (
      input  seg, an,
      output digits, known, blank, minus, dp, frame_done, multi_err, stale
   );

endinterface

// File: rtl/sseg_stable_filter.sv
// Input register and run-length filter for the scan bus. 'change' flags a
// sample that differs from the one before it; 'stable' fires on the single
// cycle where the run counter is about to reach STABLE_CYCLES, so the decoder
// can capture on the very edge the run becomes long enough. 'sample' is the
// delayed copy of the input register, which still holds the stable value on
// the cycle after that edge even if the bus has moved on.
module sseg_stable_filter #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  seg,
   input  logic [3:0]  an,
   output logic [11:0] sample,
   output logic        change,
   output logic        stable
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);

   logic [7:0]    s_q;
   logic [3:0]    a_q;
   logic [11:0]   prev_q;
   logic [CW-1:0] run_cnt;

   assign change = ({a_q, s_q} != prev_q);
   assign stable = !change && (run_cnt == CW'(STABLE_CYCLES - 1));
   assign sample = prev_q;

   // Sample the bus, keep one previous sample, count the length of the current run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q     <= 8'h00;
         a_q     <= 4'h0;
         prev_q  <= 12'h000;
         run_cnt <= '0;
      end else begin
         s_q    <= seg;
         a_q    <= an;
         prev_q <= {a_q, s_q};
         if (change) begin
            run_cnt <= CW'(1);
         end else if (run_cnt != CW'(STABLE_CYCLES)) begin
            run_cnt <= run_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Readback decoder for the multiplexed seven-segment scan bus. Each stable
// anode/segment combination is captured once, decoded back to a hex nibble
// with blank/minus/dp flags and stored per position. Frame completion,
// multiple-anode faults and bus inactivity are reported alongside.
module sseg_scan_decoder
   import sseg_pkg::*;
#(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic               clk,
   input  logic               rst_n,
   sseg_scan_decoder_if.slave bus
);

   localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

   logic [11:0]   sample;
   logic          change;
   logic          stable;

   state_t        state;
   state_t        state_next;
   logic          capture;

   logic [3:0]    anode;
   logic [7:0]    pattern;
   logic [2:0]    zero_cnt;
   logic [3:0]    sel;
   logic          multi_hit;
   glyph_hit_t    glyph;

   logic [3:0]    seen_mask;
   logic [3:0]    mask_upd;
   logic          frame_done_q;
   logic          multi_err_q;
   logic          stale_q;
   logic [IW-1:0] idle_cnt;
   logic [IW-1:0] idle_next;

   logic [15:0]   digits_w;
   logic [3:0]    known_w;
   logic [3:0]    blank_w;
   logic [3:0]    minus_w;
   logic [3:0]    dp_w;

   sseg_stable_filter #(
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_filter (
      .clk    (clk),
      .rst_n  (rst_n),
      .seg    (bus.seg),
      .an     (bus.an),
      .sample (sample),
      .change (change),
      .stable (stable)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state: one capture per stable run; a change during the capture
   // cycle starts the next run immediately instead of parking in HOLD.
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (change) state_next = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (stable) state_next = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            capture    = 1'b1;
            state_next = change ? ST_SETTLE : ST_HOLD;
         end
         ST_HOLD: begin
            if (change) state_next = ST_SETTLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Classify the captured sample: which position (if exactly one), and which glyph.
   always_comb begin
      anode    = sample[11:8];
      pattern  = sample[7:0];
      zero_cnt = 3'd0;
      for (int k = 0; k < 4; k++) begin
         zero_cnt = zero_cnt + {2'b00, ~anode[k]};
      end
      sel       = (zero_cnt == 3'd1) ? ~anode : 4'h0;
      multi_hit = capture && (zero_cnt >= 3'd2);
      glyph     = glyph_to_nibble(pattern[6:0]);
      mask_upd  = seen_mask | (capture ? sel : 4'h0);
      idle_next = capture ? '0 :
                  (idle_cnt == IW'(TIMEOUT_CYCLES)) ? idle_cnt : idle_cnt + IW'(1);
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_pos
      logic [3:0] nibble_q;
      logic       known_q;
      logic       blank_q;
      logic       minus_q;
      logic       dp_q;

      // Per-position result registers, written only when this position is captured.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            nibble_q <= 4'h0;
            known_q  <= 1'b0;
            blank_q  <= 1'b0;
            minus_q  <= 1'b0;
            dp_q     <= 1'b0;
         end else if (capture && sel[gi]) begin
            nibble_q <= glyph.hit ? glyph.nibble : 4'h0;
            known_q  <= glyph.hit;
            blank_q  <= (pattern[6:0] == SEG_BLANK);
            minus_q  <= (pattern[6:0] == SEG_MINUS);
            dp_q     <= ~pattern[7];
         end
      end

      assign digits_w[4*gi +: 4] = nibble_q;
      assign known_w[gi]         = known_q;
      assign blank_w[gi]         = blank_q;
      assign minus_w[gi]         = minus_q;
      assign dp_w[gi]            = dp_q;
   end

   // Frame tracking, sticky multi-anode fault and inactivity timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen_mask    <= 4'h0;
         frame_done_q <= 1'b0;
         multi_err_q  <= 1'b0;
         idle_cnt     <= '0;
         stale_q      <= 1'b0;
      end else begin
         if (mask_upd == 4'hF) begin
            frame_done_q <= 1'b1;
            seen_mask    <= 4'h0;
         end else begin
            frame_done_q <= 1'b0;
            seen_mask    <= mask_upd;
         end
         if (multi_hit) multi_err_q <= 1'b1;
         idle_cnt <= idle_next;
         stale_q  <= (idle_next == IW'(TIMEOUT_CYCLES));
      end
   end

   assign bus.digits     = digits_w;
   assign bus.known      = known_w;
   assign bus.blank      = blank_w;
   assign bus.minus      = minus_w;
   assign bus.dp         = dp_w;
   assign bus.frame_done = frame_done_q;
   assign bus.multi_err  = multi_err_q;
   assign bus.stale      = stale_q;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Bench for sseg_scan_decoder: directed scenarios followed by random scan
// holds, checked against a hold-level model of the decoder's rules.
module tb_sseg_scan_decoder;

   localparam int S  = 4;
   localparam int TO = 50;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   sseg_scan_decoder_if bus();

   sseg_scan_decoder #(
      .STABLE_CYCLES  (S),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int cyc     = 0;
   int fd_seen = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (bus.frame_done === 1'b1) fd_seen <= fd_seen + 1;

   // Hex glyphs 0..F, active-low, bit 0 = segment a.
   logic [6:0] gtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic [15:0] m_digits;
   logic [3:0]  m_known, m_blank, m_minus, m_dp, m_seen;
   logic        m_multi;
   int          m_frames  = 0;
   int          m_lastcap = 0;
   logic [11:0] prev_val;
   int          pend_eff [$];
   logic [11:0] pend_val [$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_digits = '0; m_known = '0; m_blank = '0; m_minus = '0; m_dp = '0;
      m_seen = '0; m_multi = 1'b0; prev_val = 12'h000;
      pend_eff.delete();
      pend_val.delete();
   endtask

   // Effect of one capture of value v, landing on edge eff.
   task automatic apply(input logic [11:0] v, input int eff);
      logic [3:0] a;
      logic [6:0] g;
      int zeros;
      int pos;
      a = v[11:8];
      g = v[6:0];
      m_lastcap = eff;
      zeros = 0;
      pos = 0;
      for (int k = 0; k < 4; k++) if (!a[k]) begin zeros++; pos = k; end
      if (zeros >= 2) begin
         m_multi = 1'b1;
      end else if (zeros == 1) begin
         m_digits[pos*4 +: 4] = 4'h0;
         m_known[pos] = 1'b0;
         for (int k = 0; k < 16; k++) begin
            if (gtab[k] == g) begin
               m_digits[pos*4 +: 4] = 4'(k);
               m_known[pos] = 1'b1;
            end
         end
         m_blank[pos] = (g == 7'h7F);
         m_minus[pos] = (g == 7'h3F);
         m_dp[pos]    = ~v[7];
         m_seen[pos]  = 1'b1;
         if (m_seen == 4'hF) begin
            m_frames++;
            m_seen = 4'h0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      while (pend_eff.size() > 0 && pend_eff[0] <= cyc) begin
         apply(pend_val[0], pend_eff[0]);
         void'(pend_eff.pop_front());
         void'(pend_val.pop_front());
      end
      chk({tag, ".digits"}, 32'(bus.digits), 32'(m_digits));
      chk({tag, ".known"},  32'(bus.known),  32'(m_known));
      chk({tag, ".blank"},  32'(bus.blank),  32'(m_blank));
      chk({tag, ".minus"},  32'(bus.minus),  32'(m_minus));
      chk({tag, ".dp"},     32'(bus.dp),     32'(m_dp));
      chk({tag, ".multi"},  32'(bus.multi_err), 32'(m_multi));
      chk({tag, ".stale"},  32'(bus.stale),  32'((cyc - m_lastcap) >= TO));
      chk({tag, ".frames"}, 32'(fd_seen),    32'(m_frames));
      $display("hold %s an=%h seg=%h cyc=%0d digits=%h known=%b frames=%0d",
               tag, bus.an, bus.seg, cyc, bus.digits, bus.known, fd_seen);
   endtask

   // Drive one value for n sampling edges; called at negedge+1.
   task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
      int start;
      bus.an  = a;
      bus.seg = s;
      start = cyc + 1;
      if (n >= S && {a, s} != prev_val) begin
         pend_eff.push_back(start + S + 1);
         pend_val.push_back({a, s});
      end
      prev_val = {a, s};
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wait_check(input int n, input string tag);
      repeat (n) @(negedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      m_lastcap = cyc;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".digits"}, 32'(bus.digits), 32'h0);
      chk({tag, ".known"},  32'(bus.known),  32'h0);
      chk({tag, ".blank"},  32'(bus.blank),  32'h0);
      chk({tag, ".minus"},  32'(bus.minus),  32'h0);
      chk({tag, ".dp"},     32'(bus.dp),     32'h0);
      chk({tag, ".fdone"},  32'(bus.frame_done), 32'h0);
      chk({tag, ".multi"},  32'(bus.multi_err),  32'h0);
      chk({tag, ".stale"},  32'(bus.stale),  32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cycles=%0d expected completion", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int fd_before;
      logic [3:0] a;
      logic [7:0] s;
      int n;
      int pick;
      int k;

      model_reset();
      bus.an  = 4'hF;
      bus.seg = 8'hFF;
      repeat (3) @(negedge clk);
      #1;
      check_zero("reset");
      release_reset();
      hold(4'hF, 8'hFF, 8);
      check_all("idle_bus");

      // Single digit '1' at position 0, dp off.
      hold(4'hE, 8'hF9, 10);
      check_all("digit1");
      chk("digit1.nib0", 32'(bus.digits[3:0]), 32'h1);
      chk("digit1.known_vec", 32'(bus.known), 32'h1);
      chk("digit1.dp_vec", 32'(bus.dp), 32'h0);

      // Full scan 0,4,F,minus.
      fd_before = fd_seen;
      hold(4'hE, 8'hC0, 20); check_all("scan_p0");
      hold(4'hD, 8'h99, 20); check_all("scan_p1");
      hold(4'hB, 8'h8E, 20); check_all("scan_p2");
      hold(4'h7, 8'hBF, 20); check_all("scan_p3");
      chk("scan.digits_vec", 32'(bus.digits), 32'h0F40);
      chk("scan.known_vec", 32'(bus.known), 32'h7);
      chk("scan.minus_vec", 32'(bus.minus), 32'h8);
      chk("scan.one_frame", 32'(fd_seen - fd_before), 32'h1);

      // Short glitch must never be captured.
      hold(4'hE, 8'hA4, 3);
      check_all("glitch_short");
      hold(4'hE, 8'hB0, 10);
      check_all("glitch_after");
      chk("glitch.nib0", 32'(bus.digits[3:0]), 32'h3);

      // Two anodes low.
      hold(4'hC, 8'hF9, 10);
      check_all("multi");
      chk("multi.flag", 32'(bus.multi_err), 32'h1);
      chk("multi.digits_kept", 32'(bus.digits), 32'h0F43);

      // Inactivity timeout and recovery.
      hold(4'hE, 8'h92, 10);
      wait_check(30, "stale_wait1");
      wait_check(20, "stale_wait2");
      chk("stale.set", 32'(bus.stale), 32'h1);
      hold(4'hD, 8'hF9, 10);
      check_all("stale_clear");
      chk("stale.cleared", 32'(bus.stale), 32'h0);

      // Reset after a partial frame; next scan starts from an empty mask.
      hold(4'hE, 8'hC0, 10); check_all("part_p0");
      hold(4'hD, 8'hA4, 10); check_all("part_p1");
      rst_n = 1'b0;
      #1;
      check_zero("midreset");
      model_reset();
      release_reset();
      fd_before = fd_seen;
      hold(4'hB, 8'hB0, 10); check_all("post_p2");
      hold(4'h7, 8'h99, 10); check_all("post_p3");
      hold(4'hE, 8'h12, 10); check_all("post_p0");
      hold(4'hD, 8'h78, 10); check_all("post_p1");
      chk("post.one_frame", 32'(fd_seen - fd_before), 32'h1);

      // Random holds of random length.
      for (int h = 0; h < 150; h++) begin
         do begin
            pick = $urandom_range(0, 19);
            a = 4'hF;
            if (pick < 16) begin
               a[pick % 4] = 1'b0;
            end else if (pick == 19) begin
               k = $urandom_range(0, 2);
               a[k] = 1'b0;
               a[k+1] = 1'b0;
            end
            pick = $urandom_range(0, 9);
            if (pick < 7)       s = {1'($urandom_range(0, 1)), gtab[$urandom_range(0, 15)]};
            else if (pick == 7) s = {1'($urandom_range(0, 1)), 7'h7F};
            else if (pick == 8) s = {1'($urandom_range(0, 1)), 7'h3F};
            else                s = 8'($urandom);
         end while ({a, s} == prev_val);
         n = $urandom_range(1, 8);
         hold(a, s, n);
         check_all("rand");
      end

      hold(4'hF, 8'hFF, 12);
      wait_check(10, "final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sseg_scan_decoder.md
# sseg_scan_decoder

Receiving end of the multiplexed seven-segment interface. It samples the active-low `seg`/`an` scan bus that the display driver produces, filters out transitions, and decodes each of the four digit positions back into a 4-bit hex value with blank, minus and decimal-point flags. It sits beside the display driver as an on-chip readback and self-check path, and also serves as the bench's display monitor.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a position is captured (range 2–255).
- `TIMEOUT_CYCLES`, default 1_000_000: cycles without any capture before `stale` asserts.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `seg`  in  8  cathodes, active-low; `seg[0]`=a … `seg[6]`=g, `seg[7]`=dp.
- `an`  in  4  anodes, active-low; `an[i]`=0 selects position i.
- `digits`  out  16  decoded nibbles; position i is in `[4i+3:4i]`.
- `known`  out  4  position holds a legal hex glyph.
- `blank`  out  4  position showed all segments off (g included).
- `minus`  out  4  position showed g only.
- `dp`  out  4  decimal point lit at position i.
- `frame_done`  out  1  one-cycle pulse when all four positions have been captured since the last pulse.
- `multi_err`  out  1  sticky; more than one anode was stably active. Cleared only by reset.
- `stale`  out  1  no capture for `TIMEOUT_CYCLES` cycles.

## Operation
- `seg`/`an` are registered once into `s_q`/`a_q`. A run counter resets to 1 whenever `{a_q,s_q}` differs from the previous sample; otherwise it increments and saturates at `STABLE_CYCLES`.
- FSM states:
  - IDLE → SETTLE on any change.
  - SETTLE → CAPTURE when the count reaches `STABLE_CYCLES`.
  - CAPTURE lasts one cycle → HOLD.
  - HOLD → SETTLE on the next change.
  - A capture fires at most once per stable run.
- In CAPTURE with `a_q` one-cold (exactly one bit 0) at index i:
  - Decode `s_q[6:0]` through the glyph table:
    - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
  - On a table hit: `digits[i]`=value, `known[i]`=1.
  - 7F gives `blank[i]`=1; 3F gives `minus[i]`=1. In both cases `known[i]`=0 and `digits[i]`=0.
  - Any other pattern clears all three flags and sets `digits[i]`=0.
  - `dp[i]` = ~`s_q[7]`.
  - Set bit i of `seen_mask`.
- In CAPTURE with `a_q`=4'hF: no update.
- In CAPTURE with two or more anode bits at 0: no update; `multi_err` is set.
- When `seen_mask` becomes 4'hF, `frame_done` pulses for one cycle and the mask clears in the same cycle. A capture that lands on the clearing cycle is counted in the new mask.
- The idle counter clears on every capture, including rejected ones. `stale` asserts when the counter reaches `TIMEOUT_CYCLES` and deasserts on the cycle after the next capture.
- Reset values: all outputs 0, FSM in IDLE, `seen_mask`=0, counters 0. Asserting reset mid-run discards any partial frame.

## Timing
- Latency: input stable from edge t → counter reaches `STABLE_CYCLES` at edge t+`STABLE_CYCLES` → outputs valid after edge t+`STABLE_CYCLES`+1.
- An input shorter than `STABLE_CYCLES` cycles is never captured.
- `frame_done` is asserted in the same cycle the fourth position's outputs update.
- `multi_err` sets on the CAPTURE edge.
- Inputs are in the `clk` domain; no synchronizer beyond the single input register.

## Structure
- Package `sseg_pkg`: glyph constants, `SEG_BLANK`=7F, `SEG_MINUS`=3F, the FSM state enum, and the function `glyph_to_nibble` returning {hit, nibble}. The table is shared with the display driver's encoder.
- One sub-module: `sseg_stable_filter`, containing the input register, run counter and stable/change strobes. The FSM and output registers live in the top module.

## Test plan
- `an`=E, `seg`=79 held 10 cycles (defaults) → after cycle 6, `digits[3:0]`=1, `known`=0001, `dp`=0.
- Scan positions 0–3 with 40, 19, 0E, 3F, 20 cycles each → `frame_done` one pulse; `digits`=0x0F40 with positions 3..0 = 0,F,4,0; `known`=0111, `minus`=1000.
- `an`=E, `seg`=24 for 3 cycles then `seg`=30 → only 3 is captured, never 2.
- `an`=C held 10 cycles → `multi_err`=1, `digits` and `seen_mask` unchanged; stays 1 until `rst_n`.
- Set `TIMEOUT_CYCLES`=50 and hold the inputs constant after a capture → `stale`=1 at 50 cycles; a new `an` change clears it after the next capture.
- Assert `rst_n`=0 after two positions have been captured → all outputs 0 immediately; the next full scan produces exactly one `frame_done`.
